// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with programmable almost-full /
//            almost-empty flags, sticky overflow/underflow error flags and a
//            selectable first-word-fall-through (FWFT) read mode.
// Ports    : clk          - clock, all state updates on rising edge
//            rst          - asynchronous active-high reset
//            buf_in       - write data (DATA_W bits)
//            wr_en        - write request
//            rd_en        - read request (FWFT: acknowledge of head word)
//            clr_err      - synchronous clear of overflow/underflow
//            buf_out      - read data (DATA_W bits)
//            buf_empty    - occupancy == 0
//            buf_full     - occupancy == DEPTH
//            almost_full  - occupancy >= AF_THRESH
//            almost_empty - occupancy <= AE_THRESH
//            fifo_counter - current occupancy, 0..DEPTH
//            overflow     - sticky: a write was rejected while full
//            underflow    - sticky: a read was rejected while empty
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          buf_in,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          buf_out,
    output logic                       buf_empty,
    output logic                       buf_full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     fifo_counter,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_af      = c_cnt_w'(AF_THRESH);
    localparam logic [c_cnt_w-1:0]  c_ae      = c_cnt_w'(AE_THRESH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);
    localparam logic                c_af_rst  = (AF_THRESH == 0);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_empty;
    logic                r_full;
    logic                r_af;
    logic                r_ae;
    logic                r_ovf;
    logic                r_udf;
    logic [DATA_W-1:0]   r_out;

    logic                w_wa;
    logic                w_ra;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_addr_w-1:0] w_wr_ptr_nxt;
    logic [c_addr_w-1:0] w_rd_ptr_nxt;

    // Acceptance uses the registered flags only, so no request input has a
    // combinational path into any flag.
    assign w_wa = wr_en && !r_full;
    assign w_ra = rd_en && !r_empty;

    // Pointers are exactly log2(DEPTH) bits, so DEPTH-1 -> 0 wraps naturally.
    assign w_wr_ptr_nxt = w_wa ? (r_wr_ptr + c_ptr_one) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_ra ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_wa, w_ra})
            2'b10:   w_cnt_nxt = r_cnt + c_cnt_one;
            2'b01:   w_cnt_nxt = r_cnt - c_cnt_one;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wa) begin
            r_mem[r_wr_ptr] <= buf_in;
        end
    end

    // Pointers, occupancy and flags. Flags come from the next-state count so
    // they change in the same cycle as fifo_counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= c_af_rst;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_empty  <= (w_cnt_nxt == '0);
            r_full   <= (w_cnt_nxt == c_depth);
            r_af     <= (w_cnt_nxt >= c_af);
            r_ae     <= (w_cnt_nxt <= c_ae);
            // A new error takes priority over a clear in the same cycle.
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_udf <= 1'b1;
            end else if (clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head after this edge is the word being written now when no
            // older word survives the edge; memory is not yet updated, so
            // bypass buf_in in that case.
            logic w_head_new;
            assign w_head_new = w_wa && (r_cnt == (w_ra ? c_cnt_one : '0));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= '0;
                end else if (w_cnt_nxt != '0) begin
                    r_out <= w_head_new ? buf_in : r_mem[w_rd_ptr_nxt];
                end
            end
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= '0;
                end else if (w_ra) begin
                    r_out <= r_mem[r_rd_ptr];
                end
            end
        end
    endgenerate

    assign buf_out      = r_out;
    assign buf_empty    = r_empty;
    assign buf_full     = r_full;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign fifo_counter = r_cnt;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Self-checking bench for sync_fifo_param, one standard-mode and
//            one FWFT instance (DEPTH=8, AF_THRESH=6, AE_THRESH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_dw = 8;
    localparam int c_depth = 8;

    logic clk;
    logic rst;

    // standard-mode instance signals
    logic [c_dw-1:0] buf_in;
    logic            wr_en, rd_en, clr_err;
    logic [c_dw-1:0] buf_out;
    logic            buf_empty, buf_full, almost_full, almost_empty;
    logic [3:0]      fifo_counter;
    logic            overflow, underflow;

    // FWFT instance signals
    logic [c_dw-1:0] f_in;
    logic            f_wr, f_rd, f_clr;
    logic [c_dw-1:0] f_out;
    logic            f_empty, f_full, f_af, f_ae;
    logic [3:0]      f_cnt;
    logic            f_ovf, f_udf;

    int n_vec;
    int n_err;

    sync_fifo_param #(.DATA_W(c_dw), .DEPTH(c_depth), .AF_THRESH(6),
                      .AE_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
        .clr_err(clr_err), .buf_out(buf_out), .buf_empty(buf_empty),
        .buf_full(buf_full), .almost_full(almost_full),
        .almost_empty(almost_empty), .fifo_counter(fifo_counter),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(c_dw), .DEPTH(c_depth), .AF_THRESH(6),
                      .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .buf_in(f_in), .wr_en(f_wr), .rd_en(f_rd),
        .clr_err(f_clr), .buf_out(f_out), .buf_empty(f_empty),
        .buf_full(f_full), .almost_full(f_af), .almost_empty(f_ae),
        .fifo_counter(f_cnt), .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] din;
        logic [7:0] out;
        int         cnt;
        logic       empty, full, af, ae, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic clr,
                       input logic [7:0] din, input logic [7:0] out,
                       input int cnt, input logic empty, input logic full,
                       input logic af, input logic ae, input logic ovf,
                       input logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.out = out;
        v.cnt = cnt; v.empty = empty; v.full = full; v.af = af; v.ae = ae;
        v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full status check of the standard-mode instance.
    task automatic chk_std(input string tag, input logic [7:0] out, input int cnt,
                           input logic empty, input logic full, input logic af,
                           input logic ae, input logic ovf, input logic udf);
        chk({tag, ".out"},   int'(buf_out), int'(out));
        chk({tag, ".cnt"},   int'(fifo_counter), cnt);
        chk({tag, ".flags"},
            int'({buf_empty, buf_full, almost_full, almost_empty, overflow, underflow}),
            int'({empty, full, af, ae, ovf, udf}));
    endtask

    // Drive one cycle of stimulus and sample 1 time unit after the edge.
    task automatic step(input logic wr, input logic rd, input logic clr,
                        input logic [7:0] din);
        @(negedge clk);
        wr_en = wr; rd_en = rd; clr_err = clr; buf_in = din;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic fstep(input logic wr, input logic rd, input logic [7:0] din);
        @(negedge clk);
        f_wr = wr; f_rd = rd; f_in = din;
        @(posedge clk);
        #1;
        f_wr = 1'b0; f_rd = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        wr_en = 0; rd_en = 0; clr_err = 0; buf_in = '0;
        f_wr = 0; f_rd = 0; f_clr = 0; f_in = '0;
        rst = 1'b1;

        // Table: fill, overflow, drain, underflow, clear.
        for (int k = 1; k <= 8; k++)
            add(1, 0, 0, 8'(k), 8'h00, k, 0, (k == 8), (k >= 6), (k <= 2), 0, 0);
        add(1, 0, 0, 8'hAA, 8'h00, 8, 0, 1, 1, 0, 1, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 0, 8'h00, 8'(k), 8 - k, (k == 8), 0, ((8 - k) >= 6),
                ((8 - k) <= 2), 1, 0);
        add(0, 1, 0, 8'h00, 8'h08, 0, 1, 0, 0, 1, 1, 1);
        add(0, 0, 1, 8'h00, 8'h08, 0, 1, 0, 0, 1, 0, 0);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_std("reset", 8'h00, 0, 1, 0, 0, 1, 0, 0);
        chk("reset.f_out", int'(f_out), 0);
        chk("reset.f_empty", int'(f_empty), 1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            chk_std($sformatf("vec%0d", i), vecs[i].out, vecs[i].cnt,
                    vecs[i].empty, vecs[i].full, vecs[i].af, vecs[i].ae,
                    vecs[i].ovf, vecs[i].udf);
        end

        // Refill with 0x11..0x18, then clear together with a rejected write.
        for (int k = 0; k < 8; k++) step(1, 0, 0, 8'(8'h11 + k));
        step(1, 0, 1, 8'hBB);
        chk_std("clr_vs_ovf", 8'h08, 8, 0, 1, 1, 0, 1, 0);

        // Both at full: read accepted, write rejected.
        step(1, 1, 0, 8'hCC);
        chk_std("both_full", 8'h11, 7, 0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 8'h00);
        chk("clr.ovf", int'(overflow), 0);

        // Drain to count 3 (remaining 0x16,0x17,0x18).
        for (int k = 0; k < 4; k++) step(0, 1, 0, 8'h00);
        chk_std("to3", 8'h15, 3, 0, 0, 0, 0, 0, 0);

        // 10 cycles of simultaneous write/read at count 3; pointers wrap.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] e;
            e = (i < 3) ? 8'(8'h16 + i) : 8'(8'h30 + i - 3);
            step(1, 1, 0, 8'(8'h30 + i));
            chk_std($sformatf("simul%0d", i), e, 3, 0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            chk($sformatf("tail%0d", i), int'(buf_out), 8'h37 + i);
        end
        chk("tail.empty", int'(buf_empty), 1);

        // FWFT instance
        fstep(1, 0, 8'h5A);
        chk("fwft.w1.out", int'(f_out), 8'h5A);
        chk("fwft.w1.empty", int'(f_empty), 0);
        fstep(1, 0, 8'h5B);
        chk("fwft.w2.out", int'(f_out), 8'h5A);
        chk("fwft.w2.cnt", int'(f_cnt), 2);
        fstep(0, 1, 8'h00);
        chk("fwft.r1.out", int'(f_out), 8'h5B);
        chk("fwft.r1.cnt", int'(f_cnt), 1);
        fstep(0, 1, 8'h00);
        chk("fwft.r2.empty", int'(f_empty), 1);
        chk("fwft.r2.hold", int'(f_out), 8'h5B);
        fstep(1, 0, 8'h5C);
        chk("fwft.w3.out", int'(f_out), 8'h5C);
        fstep(1, 1, 8'h5D);
        chk("fwft.wr1.out", int'(f_out), 8'h5D);
        chk("fwft.wr1.cnt", int'(f_cnt), 1);

        // Asynchronous reset mid-operation at count 5.
        for (int k = 0; k < 5; k++) step(1, 0, 0, 8'(8'h41 + k));
        chk("pre_rst.cnt", int'(fifo_counter), 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_std("async_rst", 8'h00, 0, 1, 0, 0, 1, 0, 0);
        chk("async_rst.f_empty", int'(f_empty), 1);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 8'h99);
        chk("post_rst.cnt", int'(fifo_counter), 1);
        step(0, 1, 0, 8'h00);
        chk_std("post_rst.rd", 8'h99, 0, 1, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the successor to the team's fixed 8-bit x 64 buffer, generalised in data width and depth. It adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer logic in the same clock domain and replaces the hand-sized buffers.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 64, number of entries; power of two, >=4
AF_THRESH, DEPTH-4, almost_full asserts when occupancy >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, almost_empty asserts when occupancy <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
buf_in  input  DATA_W  write data
wr_en  input  1  write request
rd_en  input  1  read request (FWFT: pop/acknowledge of head word)
clr_err  input  1  synchronous clear of overflow/underflow
buf_out  output  DATA_W  read data
buf_empty  output  1  occupancy == 0
buf_full  output  1  occupancy == DEPTH
almost_full  output  1  occupancy >= AF_THRESH
almost_empty  output  1  occupancy <= AE_THRESH
fifo_counter  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected because the FIFO was full
underflow  output  1  sticky: a read was rejected because the FIFO was empty

Behaviour:
- Reset (async, rst=1) values: pointers=0, fifo_counter=0, buf_empty=1, buf_full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0), overflow=0, underflow=0, buf_out=0. Memory contents are not reset.
- Reset mid-operation: all stored data is discarded. The first write after rst deasserts lands in entry 0.
- Accepted write (wa) = wr_en && !buf_full. Accepted read (ra) = rd_en && !buf_empty. Both use the registered flag values at the clock edge.
- wa: mem[wr_ptr] <= buf_in; wr_ptr advances by 1, wrapping DEPTH-1 -> 0.
- ra: rd_ptr advances by 1 with the same wrap.
- fifo_counter: +1 on wa only, -1 on ra only, unchanged on both or neither.
- All flags are registered and derived from the next-state counter, so they are valid the same cycle fifo_counter changes. There is no combinational path from wr_en/rd_en to any flag.
- When full, a write is rejected even if rd_en is asserted in the same cycle; the read proceeds. When empty, a read is rejected even if wr_en is asserted; the write proceeds.
- overflow sets on wr_en && buf_full; underflow sets on rd_en && buf_empty. Each holds until clr_err=1 or rst. If clr_err and a new error occur in the same cycle, the set wins.
- Standard mode (FWFT=0):
  - on ra, buf_out <= mem[rd_ptr], one-cycle read latency;
  - otherwise buf_out holds;
  - a rejected read leaves buf_out unchanged.
- FWFT mode (FWFT=1):
  - buf_out presents mem[rd_ptr] whenever buf_empty=0;
  - rd_en acknowledges the word, and the next word (if any) appears the following cycle;
  - a word written into an empty FIFO appears on buf_out in the cycle buf_empty falls (one cycle after the write edge);
  - while buf_empty=1, buf_out holds its last value.
- fifo_counter width is $clog2(DEPTH)+1 so that the value DEPTH is representable. Pointers are $clog2(DEPTH) bits with natural wrap.

Test Plan:
- Reset/flags, DEPTH=8, AF=6, AE=2: after rst -> fifo_counter=0, buf_empty=1, almost_empty=1, buf_full=0, overflow=0, buf_out=0.
- Fill/drain, FWFT=0: write 0x01..0x08 on consecutive cycles -> buf_full=1 after the 8th edge, almost_full=1 from count 6; read 8 times -> buf_out=0x01..0x08, each one cycle after its rd_en edge, buf_empty=1 at end.
- Overflow/underflow: with the FIFO full, wr_en with 0xAA -> overflow=1, count stays 8, 0xAA never read out; with it empty, rd_en -> underflow=1. clr_err pulse -> both 0. clr_err together with a new rejected write -> overflow stays 1.
- Simultaneous: at count 3, wr_en=rd_en=1 for 10 cycles -> count stays 3, pointers wrap past 7, data order preserved. At full, both asserted -> read accepted, write rejected, count becomes 7, overflow=1.
- FWFT=1: write 0x5A into empty -> buf_out=0x5A and buf_empty=0 on the next cycle without rd_en; write 0x5B, assert rd_en -> buf_out=0x5B next cycle.
- Reset mid-operation: at count 5, pulse rst asynchronously between edges -> flags return to reset values immediately; the next write/read returns the new data, not stale entries.
